frame_ram_sp: RTL and testbench

- Single-port synchronous pixel memory holding one 256x240 frame of 8-bit RGB332 pixels.
- The VGA output block instantiates three of these for triple buffering.
- The parent muxes the clock, address and write enable per buffer, so each instance serves either the reader or the writer at any time.
- Read data is registered, giving one-cycle read latency.

---
 rtl/frame_pkg.sv | 36 +++
 rtl/frame_ram_sp_core.sv | 25 ++
 rtl/frame_ram_sp.sv | 55 +++++
 tb/tb_frame_ram_sp.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Frame geometry and RGB332 pixel layout shared by the
// frame buffer blocks.
package frame_pkg;

    localparam int FRAME_WIDTH      = 256;
    localparam int FRAME_HEIGHT     = 240;
    localparam int FRAME_DEPTH      = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int PIXEL_WIDTH      = 8;
    localparam int FRAME_ADDR_WIDTH = 16;

    localparam int RGB_R_MSB = 7;
    localparam int RGB_R_LSB = 5;
    localparam int RGB_G_MSB = 4;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_B_MSB = 1;
    localparam int RGB_B_LSB = 0;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    function automatic logic [PIXEL_WIDTH-1:0] rgb332_pack(
        input logic [2:0] r,
        input logic [2:0] g,
        input logic [1:0] b
    );
        rgb332_t w_px;
        w_px.r = r;
        w_px.g = g;
        w_px.b = b;
        return w_px;
    endfunction

endpackage

// File: rtl/frame_ram_sp_core.sv
// Plain storage array with one write port and an unregistered
// read port; kept free of reset so it maps onto RAM primitives.
module frame_ram_sp_core #(
    parameter int DW    = 8,
    parameter int AW    = 16,
    parameter int DEPTH = 61440
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH] = '{default: '0};

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/frame_ram_sp.sv
// One frame of RGB332 pixels with a registered, write-through
// read port; out-of-range accesses are dropped and read as zero.
module frame_ram_sp
    import frame_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_WIDTH,
    parameter int ADDR_WIDTH = FRAME_ADDR_WIDTH,
    parameter int DEPTH      = FRAME_DEPTH
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q
);

    logic                  w_in_range;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] r_q;

    assign w_in_range = (32'(address) < 32'(DEPTH));
    assign w_we       = wren & w_in_range & ~aclr;
    // Keep the array index legal even when the request is not.
    assign w_addr     = w_in_range ? address : '0;

    frame_ram_sp_core #(
        .DW    (DATA_WIDTH),
        .AW    (ADDR_WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_q <= '0;
        end else if (!w_in_range) begin
            r_q <= '0;
        end else if (wren) begin
            r_q <= data;
        end else begin
            r_q <= w_rdata;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_frame_ram_sp.sv
// Directed and random checks of frame_ram_sp against a plain
// array model of the frame memory.
`timescale 1ns/1ps
module tb_frame_ram_sp;

    localparam int DEPTH = 61440;

    logic        clk;
    logic        run;
    logic        aclr;
    logic [15:0] address;
    logic [7:0]  data;
    logic        wren;
    logic [7:0]  q;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0] model [65536];
    logic [7:0] qexp;

    frame_ram_sp dut (
        .clock   (clk),
        .aclr    (aclr),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q)
    );

    initial clk = 1'b0;
    always #5 clk = run ? ~clk : 1'b0;

    task automatic check(input string tag, input logic [7:0] exp);
        checks++;
        assert (q === exp) else begin
            errors++;
            if (errors <= 25)
                $error("FAIL %s addr=%0d observed=%h expected=%h",
                       tag, address, q, exp);
        end
    endtask

    // Wait for one rising edge and apply the memory rules to the model.
    task automatic edge_and_check(input string tag);
        @(posedge clk);
        if (!aclr) begin
            if (wren && int'(address) < DEPTH)
                model[address] = data;
            qexp = (int'(address) < DEPTH) ? model[address] : 8'h00;
        end else begin
            qexp = 8'h00;
        end
        #1;
        check(tag, qexp);
    endtask

    // Present inputs, confirm q does not move before the edge, then clock.
    task automatic cyc(input string tag, input logic [15:0] a,
                       input logic [7:0] d, input logic w,
                       input logic r);
        address = a;
        data    = d;
        wren    = w;
        aclr    = r;
        if (r) qexp = 8'h00;
        #1;
        check({tag, "_pre"}, qexp);
        edge_and_check(tag);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) model[i] = 8'h00;
        run     = 1'b0;
        aclr    = 1'b1;
        address = '0;
        data    = '0;
        wren    = 1'b0;
        qexp    = 8'h00;
        #3;
        check("reset_state", 8'h00);
        run = 1'b1;
        cyc("reset_hold", 16'd0, 8'h00, 1'b0, 1'b1);

        // Asynchronous clear mid-cycle with a non-zero q.
        cyc("rst_wr", 16'd7, 8'h66, 1'b1, 1'b0);
        #2;
        aclr = 1'b1;
        qexp = 8'h00;
        #1;
        check("rst_async", 8'h00);
        cyc("rst_wr_blocked", 16'd5, 8'hAA, 1'b1, 1'b1);
        cyc("rst_release", 16'd5, 8'h00, 1'b0, 1'b0);
        cyc("rst_rd5", 16'd5, 8'h00, 1'b0, 1'b0);
        check("rst_no_write", 8'h00);

        // Latency: q only follows the new address after one edge.
        cyc("lat_wr", 16'h0100, 8'h5C, 1'b1, 1'b0);
        cyc("lat_other", 16'h0200, 8'h00, 1'b0, 1'b0);
        cyc("lat_rd", 16'h0100, 8'h00, 1'b0, 1'b0);
        check("lat_value", 8'h5C);

        // Read-during-write returns the new data.
        cyc("rdw_init", 16'h1234, 8'h11, 1'b1, 1'b0);
        cyc("rdw_away", 16'h0000, 8'h00, 1'b0, 1'b0);
        cyc("rdw_wr", 16'h1234, 8'hE3, 1'b1, 1'b0);
        check("rdw_value", 8'hE3);

        // Boundaries and out-of-range handling.
        cyc("bnd_w0", 16'd0, 8'h7F, 1'b1, 1'b0);
        cyc("bnd_wlast", 16'd61439, 8'hFF, 1'b1, 1'b0);
        cyc("bnd_r0", 16'd0, 8'h00, 1'b0, 1'b0);
        check("bnd_r0_val", 8'h7F);
        cyc("bnd_rlast", 16'd61439, 8'h00, 1'b0, 1'b0);
        check("bnd_rlast_val", 8'hFF);
        cyc("oor_wr", 16'd61440, 8'h33, 1'b1, 1'b0);
        check("oor_wr_q", 8'h00);
        cyc("oor_rd", 16'd61440, 8'h00, 1'b0, 1'b0);
        cyc("oor_r0", 16'd0, 8'h00, 1'b0, 1'b0);
        check("oor_alias0", 8'h7F);
        cyc("oor_r28672", 16'd28672, 8'h00, 1'b0, 1'b0);
        cyc("oor_r4096", 16'd4096, 8'h00, 1'b0, 1'b0);
        cyc("oor_rtop", 16'hFFFF, 8'h00, 1'b0, 1'b0);

        // Clock held low while inputs wander.
        cyc("gate_wr", 16'd10, 8'h9A, 1'b1, 1'b0);
        run = 1'b0;
        #10;
        for (int i = 0; i < 50; i++) begin
            address = 16'($urandom_range(0, 65535));
            data    = 8'($urandom);
            wren    = 1'b1;
            #20;
            check("gate_hold", 8'h9A);
        end
        address = 16'd10;
        wren    = 1'b0;
        run     = 1'b1;
        edge_and_check("gate_resume");
        check("gate_mem", 8'h9A);

        // Random traffic over a small window to force collisions.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            if ($urandom_range(0, 9) == 0)
                a = 16'($urandom_range(DEPTH - 4, 65535));
            else
                a = 16'($urandom_range(0, 63));
            cyc("rand", a, 8'($urandom), 1'($urandom),
                ($urandom_range(0, 49) == 0));
        end
        cyc("rand_end", 16'd0, 8'h00, 1'b0, 1'b0);

        // Sequential sweeps over the first rows and the last rows.
        for (int i = 0; i < 16384; i++)
            cyc("sweep_wr", 16'(i), 8'((i * 7) & 8'hFF), 1'b1, 1'b0);
        for (int i = DEPTH - 1024; i < DEPTH; i++)
            cyc("sweep_wr", 16'(i), 8'((i * 7) & 8'hFF), 1'b1, 1'b0);
        for (int i = 0; i < 16384; i++) begin
            cyc("sweep_rd", 16'(i), 8'h00, 1'b0, 1'b0);
            check("sweep_val", 8'((i * 7) & 8'hFF));
        end
        for (int i = DEPTH - 1024; i < DEPTH; i++) begin
            cyc("sweep_rd", 16'(i), 8'h00, 1'b0, 1'b0);
            check("sweep_val", 8'((i * 7) & 8'hFF));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
